// File: rtl/gpio_irq.sv
// GPIO controller: debounced inputs with edge interrupts, set/clear outputs,
// and bidirectional pads with per-bit direction, on the word-addressed chip bus.
module gpio_irq #(
    parameter int IN_CH   = 4,
    parameter int OUT_CH  = 18,
    parameter int IO_CH   = 16,
    parameter int DEB_CYC = 16,
    parameter int ADDR_W  = 30
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cs_,
    input  logic              as_,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wr_data,
    output logic [31:0]       rd_data,
    output logic              rdy_,
    output logic              irq,
    input  logic [IN_CH-1:0]  gpio_in,
    output logic [OUT_CH-1:0] gpio_out,
    inout  wire  [IO_CH-1:0]  gpio_io
);

    localparam int CW = $clog2(DEB_CYC) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYC - 1);

    // Handshake: an access is any edge sampling cs_=0 and as_=0; rdy_ is low
    // for exactly the following cycle, carrying read data when rw=1.
    logic       access;
    logic       wr_en;
    logic [3:0] reg_sel;
    logic       unused_bits;

    assign access      = ~cs_ & ~as_;
    assign wr_en       = access & ~rw;
    assign reg_sel     = addr[3:0];
    assign unused_bits = ^{addr[ADDR_W-1:4], wr_data};

    logic [OUT_CH-1:0] out_data;
    logic [IO_CH-1:0]  io_out, io_dir, io_meta, io_sync;
    logic [IN_CH-1:0]  in_meta, in_sync, filt;
    logic [IN_CH-1:0]  int_en, int_stat, int_rise, int_fall;
    logic [IN_CH-1:0]  rise, fall, w1c;
    logic [CW-1:0]     cnt [IN_CH];
    logic [31:0]       rd_mux;

    assign gpio_out = out_data;

    for (genvar g = 0; g < IO_CH; g++) begin : g_pad
        assign gpio_io[g] = io_dir[g] ? io_out[g] : 1'bz;
    end

    // Edge events fire on the same edge that filt takes the new level.
    always_comb begin
        rise = '0;
        fall = '0;
        for (int i = 0; i < IN_CH; i++) begin
            if ((in_sync[i] != filt[i]) && (cnt[i] == CNT_MAX)) begin
                rise[i] = in_sync[i];
                fall[i] = ~in_sync[i];
            end
        end
    end

    assign w1c = (wr_en && reg_sel == 4'd7) ? wr_data[IN_CH-1:0] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_meta <= '0;
            in_sync <= '0;
            filt    <= '0;
            io_meta <= '0;
            io_sync <= '0;
            for (int i = 0; i < IN_CH; i++) cnt[i] <= '0;
        end else begin
            in_meta <= gpio_in;
            in_sync <= in_meta;
            io_meta <= gpio_io;
            io_sync <= io_meta;
            for (int i = 0; i < IN_CH; i++) begin
                if (in_sync[i] == filt[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    filt[i] <= in_sync[i];
                    cnt[i]  <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data <= '0;
            io_out   <= '0;
            io_dir   <= '0;
            int_en   <= '0;
            int_rise <= '0;
            int_fall <= '0;
        end else if (wr_en) begin
            case (reg_sel)
                4'd1: out_data <= wr_data[OUT_CH-1:0];
                4'd2: out_data <= out_data | wr_data[OUT_CH-1:0];
                4'd3: out_data <= out_data & ~wr_data[OUT_CH-1:0];
                4'd4: io_out   <= wr_data[IO_CH-1:0];
                4'd5: io_dir   <= wr_data[IO_CH-1:0];
                4'd6: int_en   <= wr_data[IN_CH-1:0];
                4'd8: int_rise <= wr_data[IN_CH-1:0];
                4'd9: int_fall <= wr_data[IN_CH-1:0];
                default: ;
            endcase
        end
    end

    // A new edge on a bit overrides a simultaneous write-1-to-clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            int_stat <= '0;
            irq      <= 1'b0;
        end else begin
            int_stat <= (int_stat & ~w1c) | (rise & int_rise) | (fall & int_fall);
            irq      <= |(int_stat & int_en);
        end
    end

    always_comb begin
        rd_mux = '0;
        case (reg_sel)
            4'd0: rd_mux[IN_CH-1:0]  = filt;
            4'd1: rd_mux[OUT_CH-1:0] = out_data;
            4'd4: rd_mux[IO_CH-1:0]  = io_sync;
            4'd5: rd_mux[IO_CH-1:0]  = io_dir;
            4'd6: rd_mux[IN_CH-1:0]  = int_en;
            4'd7: rd_mux[IN_CH-1:0]  = int_stat;
            4'd8: rd_mux[IN_CH-1:0]  = int_rise;
            4'd9: rd_mux[IN_CH-1:0]  = int_fall;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdy_    <= 1'b1;
            rd_data <= '0;
        end else begin
            rdy_    <= ~access;
            rd_data <= (access && rw) ? rd_mux : '0;
        end
    end

endmodule

// File: tb/tb_gpio_irq.sv
// Directed bench for gpio_irq: bus register access, debounce, edge interrupts,
// W1C/set collision and bidirectional pads, checked with immediate assertions.
module tb_gpio_irq;

    logic        clk = 1'b0;
    logic        reset;
    logic        cs_, as_, rw;
    logic [29:0] addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        rdy_;
    logic        irq;
    logic [3:0]  gpio_in;
    logic [17:0] gpio_out;
    wire  [15:0] gpio_io;
    logic [15:0] tb_io_en;
    logic [15:0] tb_io_val;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 16; g++) begin : g_tb_pad
        assign gpio_io[g] = tb_io_en[g] ? tb_io_val[g] : 1'bz;
    end

    gpio_irq dut (
        .clk      (clk),
        .reset    (reset),
        .cs_      (cs_),
        .as_      (as_),
        .rw       (rw),
        .addr     (addr),
        .wr_data  (wr_data),
        .rd_data  (rd_data),
        .rdy_     (rdy_),
        .irq      (irq),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .gpio_io  (gpio_io)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_start(input logic [3:0] a, input logic r, input logic [31:0] d);
        @(negedge clk);
        cs_     = 1'b0;
        as_     = 1'b0;
        rw      = r;
        addr    = '0;
        addr[3:0] = a;
        wr_data = d;
    endtask

    // Called after the sampling edge: checks the one-cycle rdy_ pulse.
    task automatic bus_end(output logic [31:0] q);
        @(negedge clk);
        cs_     = 1'b1;
        as_     = 1'b1;
        rw      = 1'b1;
        wr_data = '0;
        check("rdy_low", {31'd0, rdy_}, 32'd0);
        q = rd_data;
        @(posedge clk);
        #1;
        check("rdy_high", {31'd0, rdy_}, 32'd1);
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        logic [31:0] q;
        bus_start(a, 1'b0, d);
        @(posedge clk);
        bus_end(q);
        check("wr_rd_data_zero", q, 32'd0);
    endtask

    task automatic bus_read(input string tag, input logic [3:0] a, input logic [31:0] exp);
        logic [31:0] q;
        bus_start(a, 1'b1, 32'd0);
        @(posedge clk);
        bus_end(q);
        check(tag, q, exp);
    endtask

    initial begin
        logic [31:0] q;
        reset     = 1'b1;
        cs_       = 1'b1;
        as_       = 1'b1;
        rw        = 1'b1;
        addr      = '0;
        wr_data   = '0;
        gpio_in   = 4'hF;
        tb_io_en  = 16'hFF00;
        tb_io_val = 16'h3C00;

        // Reset with all inputs held high.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rd_data", rd_data, 32'd0);
        check("rst_gpio_out", {14'd0, gpio_out}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_rdy", {31'd0, rdy_}, 32'd1);
        reset = 1'b0;
        bus_read("in_data_early", 4'd0, 32'd0);
        repeat (30) @(negedge clk);
        bus_read("in_data_settled", 4'd0, 32'h0000000F);
        bus_read("stat_after_reset", 4'd7, 32'd0);
        check("irq_after_reset", {31'd0, irq}, 32'd0);
        gpio_in = 4'h0;
        repeat (25) @(negedge clk);
        bus_read("in_data_low", 4'd0, 32'd0);

        // Output data, set and clear.
        bus_write(4'd1, 32'h0003F00F);
        bus_write(4'd2, 32'h000000F0);
        bus_write(4'd3, 32'h0000000F);
        check("gpio_out_setclr", {14'd0, gpio_out}, 32'h0003F0F0);
        bus_read("out_data_rd", 4'd1, 32'h0003F0F0);

        // Bidirectional pads: low byte driven, high byte from the bench.
        bus_write(4'd5, 32'h000000FF);
        bus_write(4'd4, 32'h0000A5A5);
        repeat (3) @(negedge clk);
        check("pad_low_byte", {24'd0, gpio_io[7:0]}, 32'h000000A5);
        bus_read("io_data_rd", 4'd4, 32'h00003CA5);
        bus_read("io_dir_rd", 4'd5, 32'h000000FF);

        // Debounce: short glitch rejected, long pulse raises irq on time.
        bus_write(4'd8, 32'h1);
        bus_write(4'd6, 32'h1);
        @(negedge clk);
        gpio_in[0] = 1'b1;
        repeat (10) @(negedge clk);
        gpio_in[0] = 1'b0;
        repeat (30) @(negedge clk);
        check("glitch_irq", {31'd0, irq}, 32'd0);
        bus_read("glitch_stat", 4'd7, 32'd0);

        @(negedge clk);
        gpio_in[0] = 1'b1;
        @(posedge clk);
        repeat (17) @(posedge clk);
        #1;
        check("irq_k17", {31'd0, irq}, 32'd0);
        @(posedge clk);
        #1;
        check("irq_k18", {31'd0, irq}, 32'd1);
        @(negedge clk);
        gpio_in[0] = 1'b0;
        repeat (25) @(negedge clk);
        bus_read("pulse_stat", 4'd7, 32'h1);
        bus_write(4'd7, 32'h1);
        check("irq_after_w1c", {31'd0, irq}, 32'd0);
        bus_read("stat_cleared", 4'd7, 32'd0);

        // Rise/fall on bit 1 with interrupts masked; W1C collides with fall.
        bus_write(4'd6, 32'h0);
        bus_write(4'd8, 32'h2);
        bus_write(4'd9, 32'h2);
        @(negedge clk);
        gpio_in[1] = 1'b1;
        repeat (25) @(negedge clk);
        check("masked_irq", {31'd0, irq}, 32'd0);
        bus_read("rise_stat", 4'd7, 32'h2);
        @(negedge clk);
        gpio_in[1] = 1'b0;
        @(posedge clk);
        repeat (16) @(posedge clk);
        bus_start(4'd7, 1'b0, 32'h2);
        @(posedge clk);
        bus_end(q);
        bus_read("set_wins_stat", 4'd7, 32'h2);
        bus_write(4'd7, 32'h2);
        bus_read("stat_w1c_final", 4'd7, 32'd0);
        check("masked_irq_end", {31'd0, irq}, 32'd0);

        // Unmapped and write-only addresses.
        bus_read("rd_addr12", 4'd12, 32'd0);
        bus_read("rd_addr2", 4'd2, 32'd0);
        bus_write(4'd12, 32'hFFFFFFFF);
        bus_read("out_after_12", 4'd1, 32'h0003F0F0);
        bus_read("dir_after_12", 4'd5, 32'h000000FF);
        bus_read("en_after_12", 4'd6, 32'd0);
        bus_read("rise_after_12", 4'd8, 32'h2);
        check("gpio_out_end", {14'd0, gpio_out}, 32'h0003F0F0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
